riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the fetch unit (IFU) and the load/store unit (LSU).
//  Sits between riscv_dp_top and the unified memory. One transaction is outstanding at a time.
//  Ties are broken round-robin. A watchdog terminates hung transactions.
//  The datapath stalls on a port until that port's ack.
// PARAMETERS
//  ADDR_W       32   byte address width
//  DATA_W       32   data width; BE width = DATA_W/8
//  TIMEOUT_CYC  255  max cycles from mem_req_o to mem_rvalid_i; 0 = watchdog disabled
// PORTS
//  clk_i          in   1         single clock, all logic on rising edge
//  rst_i          in   1         synchronous, active-high reset
//  ifu_req_i      in   1         fetch request; held with addr until ifu_ack_o
//  ifu_addr_i     in   ADDR_W    fetch address
//  ifu_rdata_o    out  DATA_W    fetched word, valid when ifu_ack_o
//  ifu_ack_o      out  1         1-cycle completion pulse
//  ifu_err_o      out  1         with ifu_ack_o: transaction timed out
//  lsu_req_i      in   1         load/store request; held with fields until lsu_ack_o
//  lsu_we_i       in   1         1 = store
//  lsu_be_i       in   DATA_W/8  byte enables (store)
//  lsu_addr_i     in   ADDR_W    data address
//  lsu_wdata_i    in   DATA_W    store data
//  lsu_rdata_o    out  DATA_W    load data, valid when lsu_ack_o
//  lsu_ack_o      out  1         1-cycle completion pulse
//  lsu_err_o      out  1         with lsu_ack_o: transaction timed out
//  mem_req_o      out  1         1-cycle issue pulse
//  mem_we_o       out  1         write strobe, valid with mem_req_o
//  mem_be_o       out  DATA_W/8  byte enables; all-ones for fetch
//  mem_addr_o     out  ADDR_W    address, held until completion
//  mem_wdata_o    out  DATA_W    write data, held until completion
//  mem_rdata_i    in   DATA_W    read data, valid with mem_rvalid_i
//  mem_rvalid_i   in   1         completion, asserted for reads and writes
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, last_grant=IFU, watchdog=0. A reset mid-transaction abandons it with no ack.
//  FSM: IDLE -> WAIT_IF | WAIT_LSU -> IDLE.
//  IDLE: a requester is eligible if req_i=1 and its ack_o is 0 this cycle.
//   Only one eligible -> grant it.
//   Both eligible -> grant the one != last_grant.
//   On grant edge: register mem_addr/we/be/wdata; mem_req_o=1 for exactly the next cycle; update last_grant.
//  WAIT_x: mem_req_o=0 after the first cycle. The counter increments each cycle.
//   mem_rvalid_i=1 -> next cycle x_ack_o=1 and x_rdata_o=mem_rdata_i (registered); go IDLE.
//   Watchdog: counter reaches TIMEOUT_CYC without rvalid -> next cycle x_ack_o=1, x_err_o=1, x_rdata_o=0; go IDLE.
//   rvalid and timeout on the same cycle -> rvalid wins, err=0.
//  Latency: req seen at edge N -> mem_req_o during cycle N+1; rvalid at edge M -> ack during cycle M+1.
//   Minimum 3 cycles with zero-wait memory; one IDLE cycle always separates transactions.
//  x_rdata_o holds its value until the next ack on that port. Stores return rdata = mem_rdata_i unchanged.
//  mem_rvalid_i in IDLE: ignored, no ack.
//  Requester protocol: req and fields stable from assertion through the ack cycle.
//   Changes before ack are a protocol violation; behaviour is undefined.
//  Counter width $clog2(TIMEOUT_CYC+1); saturates, never wraps.
// STRUCTURE
//  Package riscv_arb_pkg holds:
//   - state enum (IDLE, WAIT_IF, WAIT_LSU);
//   - grant encoding (GNT_IFU=0, GNT_LSU=1);
//   - full-byte-enable constant.
//  Sub-module riscv_arb_watchdog: clear/enable inputs, saturating counter, expired output.
//  Pick logic, FSM and output registers stay in the top.
// TESTING
//  1. IFU-only read 0x100, memory rvalid 2 cycles after mem_req_o, rdata=0xDEADBEEF
//     -> mem_be_o=4'hF, mem_we_o=0; ifu_ack_o 1 cycle with 0xDEADBEEF; lsu_ack_o stays 0.
//  2. IFU 0x0 and LSU store 0x200/0x12345678/be=4'h3 asserted same cycle, after reset
//     -> LSU granted first (last_grant=IFU), then IFU; exactly one mem_req_o per transaction.
//  3. Both requesters held continuously for 6 transactions
//     -> grants alternate IFU/LSU; no port waits more than one foreign transaction.
//  4. TIMEOUT_CYC=4, memory never answers LSU load 0x300
//     -> lsu_ack_o=1 and lsu_err_o=1 exactly 5 cycles after mem_req_o; next request proceeds normally.
//  5. rst_i pulsed in WAIT_IF, then a late mem_rvalid_i
//     -> all outputs 0, no ack; a subsequent IFU request completes correctly.
//  6. Spurious mem_rvalid_i in IDLE, and req_i kept high during its own ack cycle
//     -> no ack; no duplicate grant in the ack cycle.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the IFU/LSU unified-memory arbiter.
package riscv_arb_pkg;

  localparam int unsigned ARB_ADDR_W      = 32;
  localparam int unsigned ARB_DATA_W      = 32;
  localparam int unsigned ARB_TIMEOUT_CYC = 255;

  // Widest byte-enable vector supported; users cast down to their BE width.
  localparam int unsigned ARB_BE_MAX_W = 64;
  localparam logic [ARB_BE_MAX_W-1:0] BE_FULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IF  = 2'd1,
    ST_WAIT_LSU = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } arb_gnt_e;

  // Watchdog counter width; a disabled watchdog still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/riscv_arb_watchdog.sv
// Saturating cycle counter that flags a memory transaction as hung.
module riscv_arb_watchdog
  import riscv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // Count outstanding cycles; hold at the limit instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt <= '0;
    end else if (en_i && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A zero limit means the watchdog never fires.
  assign expired_c = (TIMEOUT_CYC != 0) && (cnt == CNT_MAX);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store.
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned DATA_W      = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_ack_o,
  output logic                ifu_err_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_ack_o,
  output logic                lsu_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = BE_W'(BE_FULL);

  arb_state_e state;
  arb_gnt_e   last_grant;
  arb_gnt_e   pick_gnt;
  logic       ifu_elig;
  logic       lsu_elig;
  logic       pick_valid;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  // Pick the next requester; a port in its ack cycle is not re-granted.
  always_comb begin
    ifu_elig   = ifu_req_i && !ifu_ack_o;
    lsu_elig   = lsu_req_i && !lsu_ack_o;
    pick_valid = ifu_elig || lsu_elig;
    pick_gnt   = GNT_IFU;
    if (ifu_elig && lsu_elig) begin
      pick_gnt = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end else if (lsu_elig) begin
      pick_gnt = GNT_LSU;
    end
  end

  // Watchdog restarts while idle and runs while a transaction is outstanding.
  assign wd_clr = (state == ST_IDLE);
  assign wd_en  = (state != ST_IDLE);

  riscv_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_c (wd_expired)
  );

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_IFU;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ifu_rdata_o <= '0;
      ifu_ack_o   <= 1'b0;
      ifu_err_o   <= 1'b0;
      lsu_rdata_o <= '0;
      lsu_ack_o   <= 1'b0;
      lsu_err_o   <= 1'b0;
    end else begin
      mem_req_o <= 1'b0;
      ifu_ack_o <= 1'b0;
      ifu_err_o <= 1'b0;
      lsu_ack_o <= 1'b0;
      lsu_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            last_grant <= pick_gnt;
            mem_req_o  <= 1'b1;
            if (pick_gnt == GNT_LSU) begin
              state       <= ST_WAIT_LSU;
              mem_we_o    <= lsu_we_i;
              mem_be_o    <= lsu_be_i;
              mem_addr_o  <= lsu_addr_i;
              mem_wdata_o <= lsu_wdata_i;
            end else begin
              state       <= ST_WAIT_IF;
              mem_we_o    <= 1'b0;
              mem_be_o    <= BE_ALL;
              mem_addr_o  <= ifu_addr_i;
              mem_wdata_o <= '0;
            end
          end
        end
        ST_WAIT_IF: begin
          if (mem_rvalid_i) begin
            state       <= ST_IDLE;
            ifu_ack_o   <= 1'b1;
            ifu_rdata_o <= mem_rdata_i;
          end else if (wd_expired) begin
            state       <= ST_IDLE;
            ifu_ack_o   <= 1'b1;
            ifu_err_o   <= 1'b1;
            ifu_rdata_o <= '0;
          end
        end
        ST_WAIT_LSU: begin
          if (mem_rvalid_i) begin
            state       <= ST_IDLE;
            lsu_ack_o   <= 1'b1;
            lsu_rdata_o <= mem_rdata_i;
          end else if (wd_expired) begin
            state       <= ST_IDLE;
            lsu_ack_o   <= 1'b1;
            lsu_err_o   <= 1'b1;
            lsu_rdata_o <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomised and directed bench for riscv_mem_arbiter against a transaction-level reference.
module tb_riscv_mem_arbiter;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned TIMEOUT_CYC = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              ifu_req_i;
  logic [ADDR_W-1:0] ifu_addr_i;
  logic [DATA_W-1:0] ifu_rdata_o;
  logic              ifu_ack_o;
  logic              ifu_err_o;
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [BE_W-1:0]   lsu_be_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_ack_o;
  logic              lsu_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;

  riscv_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ifu_req_i    (ifu_req_i),
    .ifu_addr_i   (ifu_addr_i),
    .ifu_rdata_o  (ifu_rdata_o),
    .ifu_ack_o    (ifu_ack_o),
    .ifu_err_o    (ifu_err_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_ack_o    (lsu_ack_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit                m_valid = 0;
  bit                m_clean = 0;
  int                m_owner = 0;   // 0 none, 1 IFU, 2 LSU
  int                m_last  = 0;   // 0 IFU, 1 LSU
  int                m_issue = 0;   // cycle in which mem_req_o is high
  int                m_cyc   = 0;
  logic              e_mem_req, e_we;
  logic [BE_W-1:0]   e_be;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic              e_ifu_ack, e_ifu_err, e_lsu_ack, e_lsu_err;
  logic [DATA_W-1:0] e_ifu_rdata, e_lsu_rdata;

  always @(posedge clk_i) begin : ref_model
    int k;
    bit ie, le;
    int g;
    k = m_cyc;
    m_cyc++;
    if (rst_i) begin
      m_valid = 1; m_clean = 1; m_owner = 0; m_last = 0;
      e_mem_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
      e_ifu_ack = 0; e_ifu_err = 0; e_lsu_ack = 0; e_lsu_err = 0;
      e_ifu_rdata = '0; e_lsu_rdata = '0;
    end else if (m_valid) begin
      ie = ifu_req_i && !e_ifu_ack;
      le = lsu_req_i && !e_lsu_ack;
      e_mem_req = 0; e_ifu_ack = 0; e_ifu_err = 0; e_lsu_ack = 0; e_lsu_err = 0;
      if (m_owner == 0) begin
        if (ie || le) begin
          g = (ie && le) ? 1 - m_last : (le ? 1 : 0);
          m_last = g; m_owner = g + 1; m_issue = k + 1; m_clean = 0; e_mem_req = 1;
          if (g == 1) begin
            e_addr = lsu_addr_i; e_we = lsu_we_i; e_be = lsu_be_i; e_wdata = lsu_wdata_i;
          end else begin
            e_addr = ifu_addr_i; e_we = 0; e_be = 4'hF;
          end
        end
      end else if (mem_rvalid_i || (TIMEOUT_CYC != 0 && (k - m_issue) >= int'(TIMEOUT_CYC))) begin
        if (m_owner == 1) begin
          e_ifu_ack = 1; e_ifu_err = !mem_rvalid_i; e_ifu_rdata = mem_rvalid_i ? mem_rdata_i : '0;
        end else begin
          e_lsu_ack = 1; e_lsu_err = !mem_rvalid_i; e_lsu_rdata = mem_rvalid_i ? mem_rdata_i : '0;
        end
        m_owner = 0;
      end
    end
  end

  // Compare every observable output against the reference each cycle.
  always @(negedge clk_i) begin
    if (m_valid) begin
      chk("mem_req", mem_req_o, e_mem_req);
      chk("ifu_ack", ifu_ack_o, e_ifu_ack);
      chk("ifu_err", ifu_err_o, e_ifu_err);
      chk("ifu_rdata", ifu_rdata_o, e_ifu_rdata);
      chk("lsu_ack", lsu_ack_o, e_lsu_ack);
      chk("lsu_err", lsu_err_o, e_lsu_err);
      chk("lsu_rdata", lsu_rdata_o, e_lsu_rdata);
      if (m_owner != 0 || m_clean) begin
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_be", mem_be_o, e_be);
      end
      if (m_owner == 2 || m_clean) chk("mem_wdata", mem_wdata_o, e_wdata);
    end
  end

  // ---------------- agents and logs ----------------
  typedef struct {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lreq_t;
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } mreq_t;
  typedef struct {
    int                cyc;
    int                port;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } ack_t;

  logic [ADDR_W-1:0] ifu_q[$];
  lreq_t             lsu_q[$];
  mreq_t             mreq_log[$];
  ack_t              ack_log[$];
  bit                ifu_hold_end = 0, lsu_hold_end = 0;
  int                cyc = 0;
  int                mem_cnt = -1;
  int                mem_delay_mode = 1;  // -2 random, -1 never, else fixed delay
  bit                mem_fixed_en = 0;
  logic [DATA_W-1:0] mem_fixed_data = '0;
  bit                spur_en = 0, spur_force = 0;

  task automatic tick();
    int d;
    lreq_t r;
    @(negedge clk_i);
    cyc++;
    if (mem_req_o) mreq_log.push_back('{cyc, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o});
    if (ifu_ack_o) ack_log.push_back('{cyc, 0, ifu_err_o, ifu_rdata_o});
    if (lsu_ack_o) ack_log.push_back('{cyc, 1, lsu_err_o, lsu_rdata_o});
    if (ifu_req_i && ifu_ack_o) ifu_hold_end = 1;
    else begin
      if (ifu_hold_end) begin ifu_req_i = 0; ifu_hold_end = 0; end
      if (!ifu_req_i && ifu_q.size() > 0) begin ifu_req_i = 1; ifu_addr_i = ifu_q.pop_front(); end
    end
    if (lsu_req_i && lsu_ack_o) lsu_hold_end = 1;
    else begin
      if (lsu_hold_end) begin lsu_req_i = 0; lsu_hold_end = 0; end
      if (!lsu_req_i && lsu_q.size() > 0) begin
        r = lsu_q.pop_front();
        lsu_req_i = 1; lsu_we_i = r.we; lsu_be_i = r.be; lsu_addr_i = r.addr; lsu_wdata_i = r.wdata;
      end
    end
    mem_rvalid_i = 0;
    mem_rdata_i  = $urandom();
    if (mem_req_o) begin
      if (mem_delay_mode == -2) begin
        d = int'($urandom_range(0, 6));
        mem_cnt = (d == 6) ? -1 : d;
      end else mem_cnt = mem_delay_mode;
    end
    if (mem_cnt == 0) begin
      mem_rvalid_i = 1;
      if (mem_fixed_en) mem_rdata_i = mem_fixed_data;
    end else if (mem_cnt < 0 && !mem_req_o &&
                 (spur_force || (spur_en && $urandom_range(0, 7) == 0))) begin
      mem_rvalid_i = 1;
    end
    if (mem_cnt >= 0) mem_cnt--;
  endtask

  task automatic do_reset();
    rst_i = 1;
    ifu_req_i = 0; lsu_req_i = 0;
    ifu_q.delete(); lsu_q.delete();
    ifu_hold_end = 0; lsu_hold_end = 0;
    repeat (2) tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_ifu_ack", ifu_ack_o, 0);
    chk("rst_lsu_ack", lsu_ack_o, 0);
    chk("rst_ifu_rdata", ifu_rdata_o, 0);
    rst_i = 0;
  endtask

  task automatic clear_logs();
    mreq_log.delete();
    ack_log.delete();
  endtask

  task automatic run_acks(input string name, input int n, input int budget);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin tick(); k++; end
    chk({name, "_acks"}, ack_log.size(), n);
  endtask

  initial begin
    lreq_t r;
    int    k;
    rst_i = 1; ifu_req_i = 0; ifu_addr_i = '0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_rdata_i = '0; mem_rvalid_i = 0;
    do_reset();

    // 1: IFU-only read, memory answers 2 cycles after issue
    clear_logs();
    mem_delay_mode = 2; mem_fixed_en = 1; mem_fixed_data = 32'hDEADBEEF;
    ifu_q.push_back(32'h100);
    run_acks("t1", 1, 30);
    repeat (3) tick();
    chk("t1_nreq", mreq_log.size(), 1);
    chk("t1_nack", ack_log.size(), 1);
    if (mreq_log.size() >= 1 && ack_log.size() >= 1) begin
      chk("t1_addr", mreq_log[0].addr, 32'h100);
      chk("t1_we", mreq_log[0].we, 0);
      chk("t1_be", mreq_log[0].be, 4'hF);
      chk("t1_port", ack_log[0].port, 0);
      chk("t1_rdata", ack_log[0].rdata, 32'hDEADBEEF);
      chk("t1_err", ack_log[0].err, 0);
      chk("t1_lat", ack_log[0].cyc - mreq_log[0].cyc, 3);
    end

    // 2: simultaneous requests after reset, LSU store wins first
    do_reset();
    clear_logs();
    mem_delay_mode = 1; mem_fixed_en = 0;
    ifu_q.push_back(32'h0);
    lsu_q.push_back('{1'b1, 4'h3, 32'h200, 32'h12345678});
    run_acks("t2", 2, 40);
    repeat (3) tick();
    chk("t2_nreq", mreq_log.size(), 2);
    if (mreq_log.size() >= 2 && ack_log.size() >= 2) begin
      chk("t2_addr0", mreq_log[0].addr, 32'h200);
      chk("t2_we0", mreq_log[0].we, 1);
      chk("t2_be0", mreq_log[0].be, 4'h3);
      chk("t2_wdata0", mreq_log[0].wdata, 32'h12345678);
      chk("t2_addr1", mreq_log[1].addr, 32'h0);
      chk("t2_be1", mreq_log[1].be, 4'hF);
      chk("t2_port0", ack_log[0].port, 1);
      chk("t2_port1", ack_log[1].port, 0);
    end

    // 3: both held for six transactions, grants alternate starting with LSU
    clear_logs();
    mem_delay_mode = 0;
    for (int i = 0; i < 3; i++) begin
      ifu_q.push_back(32'h1000 + 32'(4 * i));
      lsu_q.push_back('{1'b0, 4'hF, 32'h2000 + 32'(4 * i), 32'h0});
    end
    run_acks("t3", 6, 80);
    repeat (3) tick();
    chk("t3_nreq", mreq_log.size(), 6);
    if (mreq_log.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        chk("t3_order", mreq_log[i].addr,
            ((i % 2) == 0) ? 32'h2000 + 32'(4 * (i / 2)) : 32'h1000 + 32'(4 * (i / 2)));
    end

    // 4: hung LSU load times out, then a normal load completes
    clear_logs();
    mem_delay_mode = -1;
    lsu_q.push_back('{1'b0, 4'hF, 32'h300, 32'h0});
    run_acks("t4", 1, 30);
    repeat (2) tick();
    chk("t4_nreq", mreq_log.size(), 1);
    if (mreq_log.size() >= 1 && ack_log.size() >= 1) begin
      chk("t4_port", ack_log[0].port, 1);
      chk("t4_err", ack_log[0].err, 1);
      chk("t4_rdata", ack_log[0].rdata, 0);
      chk("t4_lat", ack_log[0].cyc - mreq_log[0].cyc, 5);
    end
    clear_logs();
    mem_delay_mode = 1; mem_fixed_en = 1; mem_fixed_data = 32'hCAFEF00D;
    lsu_q.push_back('{1'b0, 4'hF, 32'h304, 32'h0});
    run_acks("t4b", 1, 30);
    repeat (2) tick();
    if (mreq_log.size() >= 1 && ack_log.size() >= 1) begin
      chk("t4b_addr", mreq_log[0].addr, 32'h304);
      chk("t4b_err", ack_log[0].err, 0);
      chk("t4b_rdata", ack_log[0].rdata, 32'hCAFEF00D);
    end

    // 5: reset while waiting on a fetch, late rvalid must be ignored
    clear_logs();
    mem_delay_mode = 4; mem_fixed_en = 0;
    ifu_q.push_back(32'h400);
    k = 0;
    while (mreq_log.size() < 1 && k < 20) begin tick(); k++; end
    chk("t5_issue", mreq_log.size(), 1);
    rst_i = 1; ifu_req_i = 0; ifu_q.delete(); ifu_hold_end = 0;
    tick();
    rst_i = 0;
    chk("t5_mem_req", mem_req_o, 0);
    chk("t5_mem_addr", mem_addr_o, 0);
    chk("t5_ifu_ack", ifu_ack_o, 0);
    chk("t5_ifu_rdata", ifu_rdata_o, 0);
    repeat (6) tick();
    chk("t5_noack", ack_log.size(), 0);
    clear_logs();
    mem_delay_mode = 1; mem_fixed_en = 1; mem_fixed_data = 32'h0BADF00D;
    ifu_q.push_back(32'h404);
    run_acks("t5b", 1, 30);
    repeat (3) tick();
    if (mreq_log.size() >= 1 && ack_log.size() >= 1) begin
      chk("t5b_addr", mreq_log[0].addr, 32'h404);
      chk("t5b_err", ack_log[0].err, 0);
      chk("t5b_rdata", ack_log[0].rdata, 32'h0BADF00D);
    end

    // 6: spurious rvalid in idle, and req still high in its own ack cycle
    clear_logs();
    mem_fixed_en = 0;
    spur_force = 1;
    repeat (6) tick();
    spur_force = 0;
    chk("t6_spur_ack", ack_log.size(), 0);
    chk("t6_spur_req", mreq_log.size(), 0);
    mem_delay_mode = 0;
    ifu_q.push_back(32'h500);
    repeat (12) tick();
    chk("t6_nreq", mreq_log.size(), 1);
    chk("t6_nack", ack_log.size(), 1);

    // 7: random traffic with random latency, hangs and spurious completions
    clear_logs();
    mem_delay_mode = -2; spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if (ifu_q.size() == 0 && $urandom_range(0, 3) == 0)
        ifu_q.push_back($urandom() & 32'hFFFF_FFFC);
      if (lsu_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        r.we = 1'($urandom_range(0, 1));
        r.be = 4'($urandom());
        r.addr = $urandom() & 32'hFFFF_FFFC;
        r.wdata = $urandom();
        lsu_q.push_back(r);
      end
      tick();
    end
    k = 0;
    while ((ifu_req_i || lsu_req_i || ifu_q.size() > 0 || lsu_q.size() > 0) && k < 200) begin
      tick(); k++;
    end
    chk("t7_drained", (ifu_req_i || lsu_req_i) ? 1 : 0, 0);
    chk("t7_activity", (ack_log.size() > 50) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
